// File: rtl/pcm24_to_dsp64.sv
// pcm24_to_dsp64: widens signed 24-bit PCM samples into signed 64-bit
// fixed-point words (sign-extend, then shift left by SHIFT), behind a
// valid/ready pipeline stage with a one-entry skid buffer. It also keeps an
// output-handshake counter.
// Optional build macro CLIP_DETECT_EN enables full-scale input detection.
// Without that macro, clip_flag and clip_count are held at 0.
module pcm24_to_dsp64 #(
    parameter int SHIFT = 8,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [23:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [63:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] sample_count,
    input  logic             clip_clr,
    output logic             clip_flag,
    output logic [15:0]      clip_count
);

    // Shifts above 40 would push the sign bit out of the 64-bit word.
    if (SHIFT < 0 || SHIFT > 40) begin : g_bad_shift
        $fatal(1, "pcm24_to_dsp64: SHIFT=%0d outside 0..40", SHIFT);
    end

    logic        accept;
    logic        transfer;
    logic        skid_full;
    logic [63:0] skid_data;
    logic [63:0] widened;

    assign accept   = in_valid & in_ready;
    assign transfer = out_valid & out_ready;
    // in_ready comes straight from the skid flop, so it drops the cycle after
    // the skid fills and rises the cycle after the skid drains.
    assign in_ready = ~skid_full;

    // Sign-extend the sample to 64 bits, then place input bit 0 at bit SHIFT.
    always_comb begin
        widened = {{40{in_data[23]}}, in_data} << SHIFT;
    end

    // Main register and skid buffer: accepted input goes to main when main
    // is free, and to the skid when main is stalled. Main refills from the
    // skid on each transfer.
    // NOTE: registers use non-blocking assignments, so each branch below
    // reads the values held before this clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            skid_data <= '0;
            skid_full <= 1'b0;
        end else if (skid_full) begin
            // in_ready is low here, so no new input can arrive.
            if (transfer) begin
                out_data  <= skid_data;
                out_valid <= 1'b1;
                skid_full <= 1'b0;
            end
        end else if (accept) begin
            if (!out_valid || out_ready) begin
                out_data  <= widened;
                out_valid <= 1'b1;
            end else begin
                skid_data <= widened;
                skid_full <= 1'b1;
            end
        end else if (transfer) begin
            out_valid <= 1'b0;
        end
    end

    // Count completed output handshakes. The counter wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_count <= '0;
        end else if (transfer) begin
            sample_count <= sample_count + 1'b1;
        end
    end

`ifdef CLIP_DETECT_EN
    logic full_scale;

    assign full_scale = (in_data == 24'h7FFFFF) || (in_data == 24'h800000);

    // Sticky flag and saturating count of full-scale accepts. A full-scale
    // accept in the same cycle as a clear wins and restarts the count at 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clip_flag  <= 1'b0;
            clip_count <= '0;
        end else if (accept && full_scale) begin
            clip_flag <= 1'b1;
            if (clip_clr) begin
                clip_count <= 16'd1;
            end else if (clip_count != 16'hFFFF) begin
                clip_count <= clip_count + 16'd1;
            end
        end else if (clip_clr) begin
            clip_flag  <= 1'b0;
            clip_count <= '0;
        end
    end
`else
    logic unused_clip_clr;

    assign unused_clip_clr = clip_clr;
    assign clip_flag       = 1'b0;
    assign clip_count      = '0;
`endif

endmodule

// File: tb/tb_pcm24_to_dsp64.sv
// Directed testbench for pcm24_to_dsp64 (SHIFT=8). A second instance uses
// CNT_W=4 to exercise counter wrap. Expected clip behaviour follows whether
// CLIP_DETECT_EN is defined.
module tb_pcm24_to_dsp64;

`ifdef CLIP_DETECT_EN
    localparam bit CLIP = 1'b1;
`else
    localparam bit CLIP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [23:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sample_count;
    logic        clip_clr;
    logic        clip_flag;
    logic [15:0] clip_count;

    logic [23:0] w_in_data;
    logic        w_in_valid;
    logic        w_in_ready;
    logic [63:0] w_out_data;
    logic        w_out_valid;
    logic [3:0]  w_count;
    logic        w_clip_flag;
    logic [15:0] w_clip_count;

    int errors = 0;
    int checks = 0;
    logic [63:0] got[$];

    pcm24_to_dsp64 #(.SHIFT(8), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .sample_count(sample_count),
        .clip_clr(clip_clr), .clip_flag(clip_flag), .clip_count(clip_count)
    );

    pcm24_to_dsp64 #(.SHIFT(8), .CNT_W(4)) dut_w4 (
        .clk(clk), .rst(rst),
        .in_data(w_in_data), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .out_data(w_out_data), .out_valid(w_out_valid), .out_ready(1'b1),
        .sample_count(w_count),
        .clip_clr(1'b0), .clip_flag(w_clip_flag), .clip_count(w_clip_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Record every completed output handshake of the main instance.
    always @(posedge clk) begin
        if (!rst && out_valid && out_ready) got.push_back(out_data);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          k;
        int          rt_bad;
        logic        acc;
        logic [23:0] s;
        logic [63:0] exp_w;

        rst = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b0; clip_clr = 1'b0;
        w_in_data = 24'h000123; w_in_valid = 1'b0;
        step(); step();

        // Reset state
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_data", out_data, 0);
        check("rst_count", sample_count, 0);
        check("rst_clip_flag", clip_flag, 0);
        check("rst_clip_count", clip_count, 0);
        rst = 1'b0;
        step();

        // Conversion values with out_ready held high
        out_ready = 1'b1; in_valid = 1'b1;
        in_data = 24'h000001; step();
        check("conv_one", out_data, 64'h0000_0000_0000_0100);
        check("conv_one_valid", out_valid, 1);
        in_data = 24'h7FFFFF; step();
        check("conv_max", out_data, 64'h0000_0000_7FFF_FF00);
        in_data = 24'h000000; step();
        check("conv_zero", out_data, 64'h0);
        in_data = 24'h800000; step();
        check("conv_min", out_data, 64'hFFFF_FFFF_8000_0000);
        check("clip_flag_two", clip_flag, CLIP ? 1 : 0);
        check("clip_count_two", clip_count, CLIP ? 2 : 0);
        in_valid = 1'b0; step();
        check("drain_valid", out_valid, 0);
        check("count_four", sample_count, 4);

        // Clear coincident with a full-scale accept: set wins
        in_valid = 1'b1; in_data = 24'h800000; clip_clr = 1'b1; step();
        check("clr_set_flag", clip_flag, CLIP ? 1 : 0);
        check("clr_set_count", clip_count, CLIP ? 1 : 0);
        in_valid = 1'b0; step();
        clip_clr = 1'b0;
        check("clr_flag", clip_flag, 0);
        check("clr_count", clip_count, 0);
        check("count_five", sample_count, 5);

        // Round trip: 1000 random samples
        rt_bad = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            s = 24'($urandom);
            in_data = s;
            exp_w = {{32{s[23]}}, s, 8'h00};
            step();
            if (out_data[31:8] !== s || out_data !== exp_w || out_valid !== 1'b1) rt_bad++;
        end
        in_valid = 1'b0; step();
        check("roundtrip_mismatches", rt_bad, 0);
        check("roundtrip_count", sample_count, 1005);

        // Backpressure: stream 1..16, out_ready low on edges 3..6
        got.delete();
        k = 1;
        for (int c = 1; c <= 21; c++) begin
            out_ready = (c < 3 || c > 6);
            in_valid  = (k <= 16);
            in_data   = 24'(k);
            acc = in_valid && in_ready;
            step();
            if (acc) k++;
            if (c == 2) check("bp_ready_before_fill", in_ready, 1);
            if (c == 3) check("bp_ready_drop", in_ready, 0);
            if (c >= 4 && c <= 6) begin
                check("bp_stall_data", out_data, 64'h200);
                check("bp_stall_valid", out_valid, 1);
                check("bp_stall_ready", in_ready, 0);
            end
            if (c == 7) begin
                check("bp_ready_back", in_ready, 1);
                check("bp_skid_to_main", out_data, 64'h300);
            end
        end
        check("bp_output_total", got.size(), 16);
        for (int i = 0; i < 16 && i < got.size(); i++) begin
            check($sformatf("bp_order_%0d", i + 1), got[i], 64'(i + 1) << 8);
        end
        check("bp_count", sample_count, 1021);

        // Reset mid-stream with main and skid both full
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 24'h000111; step();
        in_data = 24'h000222; step();
        check("pre_rst_ready", in_ready, 0);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_count", sample_count, 0);
        in_valid = 1'b0;
        step();
        rst = 1'b0;
        got.delete();
        step();
        out_ready = 1'b1; in_valid = 1'b1; in_data = 24'h000ABC; step();
        check("post_rst_data", out_data, 64'h0000_0000_000A_BC00);
        in_valid = 1'b0; step();
        check("post_rst_outputs", got.size(), 1);
        if (got.size() > 0) check("post_rst_first", got[0], 64'h0000_0000_000A_BC00);

        // Counter wrap on the CNT_W=4 instance: 17 transfers
        w_in_valid = 1'b1;
        for (int i = 0; i < 17; i++) step();
        w_in_valid = 1'b0;
        step(); step();
        check("wrap_count", w_count, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
